ms_timer: RTL and testbench

MS_TIMER -- requirements
Module: ms_timer

---
 rtl/ms_timer_if.sv | 25 ++
 rtl/ms_timer.sv | 155 +++++++++++++++
 tb/tb_ms_timer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ms_timer_if.sv
// ms_timer_if: register bus between a host and ms_timer.
// The host drives strobes, address and write data; the timer returns registered read data.
interface ms_timer_if;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output wr_en,
        output rd_en,
        output addr,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  addr,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/ms_timer.sv
// ms_timer: millisecond countdown timer driven by an upstream free-running ms counter.
// Registers: 0 CTRL {irq_en, periodic, enable}, 1 PERIOD, 2 STATUS {expired, W1C}, 3 REMAINING (RO).
// Elapsed time is taken as the modulo-2^32 difference of successive ms_counter samples,
// so counter wrap and multi-millisecond jumps are absorbed naturally.
// Build option: define MS_TIMER_PERIODIC_EN for periodic auto-reload; without it
// CTRL.periodic is tied to 0 and the timer is one-shot only.
module ms_timer #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ms_counter,
    ms_timer_if.slave   bus,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRED
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        enable;
    logic        enable_nx;
    logic        periodic;
    logic        periodic_nx;
    logic        irq_en;
    logic        irq_en_nx;
    logic        expired;
    logic        expired_nx;
    logic [31:0] period;
    logic [31:0] period_nx;
    logic [31:0] remaining;
    logic [31:0] remaining_nx;
    logic [31:0] prev;
    logic [31:0] prev_nx;
    logic [31:0] delta;

    logic        ctrl_wr;
    logic        period_wr;
    logic        status_wr;
    logic        arm;
    logic        disarm;

    assign ctrl_wr   = bus.wr_en && (bus.addr == 2'd0);
    assign period_wr = bus.wr_en && (bus.addr == 2'd1);
    assign status_wr = bus.wr_en && (bus.addr == 2'd2);
    assign arm       = ctrl_wr && bus.wr_data[0] && !enable;
    assign disarm    = ctrl_wr && !bus.wr_data[0];
    assign delta     = ms_counter - prev;

    // A zero period would never advance in periodic mode, so it reloads as one tick.
    function automatic logic [31:0] load_value(input logic per, input logic [31:0] p);
        return (per && (p == '0)) ? 32'd1 : p;
    endfunction

    // Next-state and register-update decode; expiry is applied after the W1C clear so it wins.
    always_comb begin
        state_nx     = state;
        enable_nx    = enable;
        periodic_nx  = periodic;
        irq_en_nx    = irq_en;
        expired_nx   = expired;
        period_nx    = period;
        remaining_nx = remaining;
        prev_nx      = prev;

        if (ctrl_wr) begin
            enable_nx = bus.wr_data[0];
`ifdef MS_TIMER_PERIODIC_EN
            periodic_nx = bus.wr_data[1];
`endif
            irq_en_nx = bus.wr_data[2];
        end
        if (period_wr) begin
            period_nx = bus.wr_data;
        end
        if (status_wr && bus.wr_data[0]) begin
            expired_nx = 1'b0;
        end

        case (state)
            IDLE, FIRED: begin
                if (arm) begin
                    state_nx     = ARMED;
                    remaining_nx = load_value(periodic_nx, period);
                    prev_nx      = ms_counter;
                end
            end
            ARMED: begin
                if (disarm) begin
                    // Disable beats a same-cycle expiry; REMAINING keeps its value.
                    state_nx = IDLE;
                end else begin
                    prev_nx = ms_counter;
                    if (delta >= remaining) begin
                        expired_nx = 1'b1;
                        if (periodic) begin
                            remaining_nx = load_value(1'b1, period);
                        end else begin
                            remaining_nx = '0;
                            enable_nx    = 1'b0;
                            state_nx     = FIRED;
                        end
                    end else begin
                        remaining_nx = remaining - delta;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and register file update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            enable    <= 1'b0;
            periodic  <= 1'b0;
            irq_en    <= 1'b0;
            expired   <= 1'b0;
            period    <= DEFAULT_PERIOD;
            remaining <= '0;
            prev      <= '0;
        end else begin
            state     <= state_nx;
            enable    <= enable_nx;
            periodic  <= periodic_nx;
            irq_en    <= irq_en_nx;
            expired   <= expired_nx;
            period    <= period_nx;
            remaining <= remaining_nx;
            prev      <= prev_nx;
        end
    end

    // Registered read port; returns the pre-update register value and holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_data <= '0;
        end else if (bus.rd_en) begin
            case (bus.addr)
                2'd0:    bus.rd_data <= {29'd0, irq_en, periodic, enable};
                2'd1:    bus.rd_data <= period;
                2'd2:    bus.rd_data <= {31'd0, expired};
                default: bus.rd_data <= remaining;
            endcase
        end
    end

    assign irq = expired & irq_en;

endmodule

// File: tb/tb_ms_timer.sv
// tb_ms_timer: directed scenarios plus randomized register/counter traffic for ms_timer,
// checked every cycle against an elapsed-time reference model.
module tb_ms_timer;

    logic        clk;
    logic        reset;
    logic [31:0] ms_counter;
    logic        irq;
    logic [31:0] cnt;

    int unsigned n_cmp;
    int unsigned n_bad;

    ms_timer_if bus ();

    ms_timer #(
        .DEFAULT_PERIOD(32'd1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ms_counter (ms_counter),
        .bus        (bus),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a loaded interval and the time used from it since arming/reload.
    logic        m_en;
    logic        m_per;
    logic        m_irqen;
    logic        m_exp;
    logic        m_armed;
    logic [31:0] m_period;
    logic [31:0] m_load;
    logic [31:0] m_used;
    logic [31:0] m_last;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en     = 1'b0;
        m_per    = 1'b0;
        m_irqen  = 1'b0;
        m_exp    = 1'b0;
        m_armed  = 1'b0;
        m_period = 32'd1000;
        m_load   = '0;
        m_used   = '0;
        m_last   = '0;
        m_rd     = '0;
    endtask

    function automatic logic [31:0] eff_period(input logic per, input logic [31:0] p);
        if (per && p == 32'd0) return 32'd1;
        return p;
    endfunction

    function automatic logic [31:0] reg_view(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_irqen, m_per, m_en};
            2'd1:    return m_period;
            2'd2:    return {31'd0, m_exp};
            default: return m_load - m_used;
        endcase
    endfunction

    task automatic model_step(input logic w, input logic r, input logic [1:0] a,
                              input logic [31:0] d, input logic [31:0] c);
        logic        old_per;
        logic        fired;
        logic        arm;
        logic        dis;
        logic [31:0] dt;
        old_per = m_per;
        fired   = 1'b0;
        if (r) m_rd = reg_view(a);
        arm = w && (a == 2'd0) && d[0] && !m_en;
        dis = w && (a == 2'd0) && !d[0];
        if (w && a == 2'd0) begin
            m_en = d[0];
`ifdef MS_TIMER_PERIODIC_EN
            m_per = d[1];
`endif
            m_irqen = d[2];
        end
        if (m_armed) begin
            if (dis) begin
                m_armed = 1'b0;
            end else begin
                dt     = c - m_last;
                m_last = c;
                if (({1'b0, m_used} + {1'b0, dt}) >= {1'b0, m_load}) begin
                    fired = 1'b1;
                    if (old_per) begin
                        m_load = eff_period(1'b1, m_period);
                        m_used = '0;
                    end else begin
                        m_load  = '0;
                        m_used  = '0;
                        m_armed = 1'b0;
                        m_en    = 1'b0;
                    end
                end else begin
                    m_used = m_used + dt;
                end
            end
        end else if (arm) begin
            m_armed = 1'b1;
            m_load  = eff_period(m_per, m_period);
            m_used  = '0;
            m_last  = c;
        end
        if (w && a == 2'd1) m_period = d;
        if (w && a == 2'd2 && d[0]) m_exp = 1'b0;
        if (fired) m_exp = 1'b1;
    endtask

    task automatic tick(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.addr    = a;
        bus.wr_data = d;
        ms_counter  = cnt;
        model_step(w, r, a, d, cnt);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("rd_data", bus.rd_data, m_rd);
        check("irq", {31'd0, irq}, {31'd0, m_exp & m_irqen});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
        tick(1'b0, 1'b1, a, 32'd0);
        check(tag, bus.rd_data, exp);
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cnt = cnt + 32'd1;
            tick(1'b0, 1'b0, 2'd0, 32'd0);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        cnt         = '0;
        ms_counter  = '0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.addr    = 2'd0;
        bus.wr_data = '0;
        reset       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset values
        rd_expect("rst_ctrl", 2'd0, 32'd0);
        rd_expect("rst_period", 2'd1, 32'd1000);
        rd_expect("rst_status", 2'd2, 32'd0);
        rd_expect("rst_remaining", 2'd3, 32'd0);

        // One-shot: PERIOD=5 armed at 100
        cnt = 32'd100;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'd1);
        step(4);
        rd_expect("os_rem_104", 2'd3, 32'd1);
        step(1);
        rd_expect("os_status", 2'd2, 32'd1);
        rd_expect("os_rem", 2'd3, 32'd0);
        rd_expect("os_ctrl", 2'd0, 32'd0);
        wr(2'd2, 32'd0);
        rd_expect("os_w0_noeffect", 2'd2, 32'd1);
        wr(2'd2, 32'd1);
        rd_expect("os_w1c", 2'd2, 32'd0);

        // Counter wrap: PERIOD=4 armed at 0xFFFF_FFFE
        wr(2'd1, 32'd4);
        cnt = 32'hFFFF_FFFE;
        wr(2'd0, 32'd1);
        step(3);
        rd_expect("wrap_pre", 2'd2, 32'd0);
        step(1);
        rd_expect("wrap_status", 2'd2, 32'd1);
        wr(2'd2, 32'd1);

        // Jump: 50 -> 53 -> 70 with PERIOD=10
        wr(2'd1, 32'd10);
        cnt = 32'd50;
        wr(2'd0, 32'd1);
        cnt = 32'd53;
        tick(1'b0, 1'b0, 2'd0, 32'd0);
        rd_expect("jump_rem", 2'd3, 32'd7);
        cnt = 32'd70;
        tick(1'b0, 1'b0, 2'd0, 32'd0);
        rd_expect("jump_status", 2'd2, 32'd1);
        rd_expect("jump_rem0", 2'd3, 32'd0);
        wr(2'd2, 32'd1);

        // Disable mid-count freezes REMAINING
        wr(2'd1, 32'd8);
        cnt = 32'd200;
        wr(2'd0, 32'd1);
        step(3);
        wr(2'd3, 32'hDEAD_BEEF);
        rd_expect("dis_rem", 2'd3, 32'd5);
        wr(2'd0, 32'd0);
        step(20);
        rd_expect("dis_frozen", 2'd3, 32'd5);
        rd_expect("dis_status", 2'd2, 32'd0);

        // Disable in the same cycle as an expiry
        wr(2'd1, 32'd2);
        cnt = 32'd400;
        wr(2'd0, 32'd1);
        cnt = 32'd405;
        wr(2'd0, 32'd0);
        rd_expect("prio_status", 2'd2, 32'd0);
        rd_expect("prio_rem", 2'd3, 32'd2);

`ifdef MS_TIMER_PERIODIC_EN
        // Periodic reload every 3 ms with irq and W1C race
        wr(2'd1, 32'd3);
        cnt = 32'd300;
        wr(2'd0, 32'd7);
        rd_expect("per_ctrl", 2'd0, 32'd7);
        step(3);
        check("per_irq_303", {31'd0, irq}, 32'd1);
        cnt = 32'd304;
        wr(2'd2, 32'd1);
        check("per_irq_clr", {31'd0, irq}, 32'd0);
        step(1);
        cnt = 32'd306;
        wr(2'd2, 32'd1);
        check("per_w1c_race", {31'd0, irq}, 32'd1);
        cnt = 32'd307;
        wr(2'd2, 32'd1);
        check("per_irq_clr2", {31'd0, irq}, 32'd0);
        step(2);
        check("per_irq_309", {31'd0, irq}, 32'd1);
        rd_expect("per_rem", 2'd3, 32'd3);
        wr(2'd0, 32'd0);
        wr(2'd2, 32'd1);
`else
        // Periodic bit tied off: one-shot only
        wr(2'd1, 32'd2);
        cnt = 32'd500;
        wr(2'd0, 32'd7);
        rd_expect("nop_ctrl", 2'd0, 32'd5);
        step(2);
        check("nop_irq", {31'd0, irq}, 32'd1);
        rd_expect("nop_ctrl_after", 2'd0, 32'd4);
        rd_expect("nop_rem", 2'd3, 32'd0);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd0);
`endif

        // Reset in the middle of an armed countdown
        wr(2'd1, 32'd8);
        cnt = 32'd600;
        wr(2'd0, 32'd5);
        step(2);
        rd_expect("mid_period", 2'd1, 32'd8);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_rd_data", bus.rd_data, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        step(20);
        rd_expect("post_rst_status", 2'd2, 32'd0);
        rd_expect("post_rst_ctrl", 2'd0, 32'd0);
        rd_expect("post_rst_period", 2'd1, 32'd1000);
        rd_expect("post_rst_rem", 2'd3, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int unsigned k;
            int unsigned sel;
            logic        r;
            logic [1:0]  a;
            k   = $urandom_range(0, 99);
            sel = $urandom_range(0, 99);
            r   = 1'($urandom_range(0, 1));
            a   = 2'($urandom_range(0, 3));
            if (k < 45) cnt = cnt + 32'd1;
            else if (k < 70) cnt = cnt;
            else if (k < 92) cnt = cnt + 32'($urandom_range(2, 6));
            else if (k < 97) cnt = cnt + 32'($urandom_range(7, 40));
            else cnt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            if (sel < 10) tick(1'b1, r, 2'd0, $urandom);
            else if (sel < 20) tick(1'b1, r, 2'd1, 32'($urandom_range(0, 6)));
            else if (sel < 28) tick(1'b1, r, 2'd2, $urandom);
            else if (sel < 33) tick(1'b1, r, 2'd3, $urandom);
            else if (sel < 75) tick(1'b0, 1'b1, a, 32'd0);
            else tick(1'b0, 1'b0, 2'd0, 32'd0);
        end
        rd_expect("final_status", 2'd2, reg_view(2'd2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
